fdce_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one DATA_W-bit clock-enabled capture register among NUM_REQ requesters.
- The register is built from FDCE-style flops.
- Decides which requester loads the register, drives its CE/D, holds the captured value for a bounded window, and services synchronous clear requests.
- Sits between requesting datapath stages and a single shared configuration/result register in the Verilator-compatible primitive library.

---
 rtl/fdce_share_arb_pkg.sv | 23 ++
 rtl/fdce_share_rr_pick.sv | 40 ++++
 rtl/fdce_share_arb.sv | 174 +++++++++++++++++
 tb/tb_fdce_share_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fdce_share_arb_pkg.sv
// fdce_share_arb_pkg
// Shared types and constants for the fdce_share_arb register-sharing arbiter.
//   state_t   : arbiter sequencing states (IDLE, HOLD, CLEAR)
//   CNT_W     : width of the hold-window down-counter (covers HOLD_CYCLES up to 255)
//   SAT_W     : width of each saturating per-requester grant counter
//   own_w()   : owner-index width for a given requester count
package fdce_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int CNT_W = 8;
  localparam int SAT_W = 16;

  // Index width needed to name one of n requesters (n >= 2).
  function automatic int own_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fdce_share_rr_pick.sv
// fdce_share_rr_pick
// Combinational round-robin priority picker. Searches req upward from ptr,
// wrapping at NUM_REQ, and reports the first set bit.
// Ports:
//   req   [NUM_REQ-1:0] in  : request vector
//   ptr   [OWN_W-1:0]   in  : search start position (always < NUM_REQ)
//   grant [NUM_REQ-1:0] out : one-hot winner (all zero when no request)
//   idx   [OWN_W-1:0]   out : encoded winner index
//   any                 out : at least one request present
module fdce_share_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [OWN_W-1:0]   idx,
  output logic               any
);

  int k;

  // Walk the requesters in rotated order; the first hit wins and later
  // hits are masked by 'any'.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = OWN_W'(k);
      end
    end
  end

endmodule

// File: rtl/fdce_share_arb.sv
// fdce_share_arb
// Round-robin arbiter and sequencer sharing one DATA_W-bit clock-enabled
// capture register (FDCE-style: async clear-to-INIT, clock enable) among
// NUM_REQ requesters. A winner loads the register and owns it for a hold
// window of HOLD_CYCLES cycles (shortened by rel); a clear request zeroes the
// register and is followed by one dead CLEAR cycle.
// Optional feature: define FDCE_SHARE_ARB_STATS_EN to add grant_cnt, a set of
// saturating 16-bit per-requester grant counters.
// Ports:
//   C          in  : clock, rising edge
//   _w_CLR     in  : asynchronous active-high reset
//   req_valid  in  : per-requester load request
//   req_data   in  : per-requester data, slice i = [i*DATA_W +: DATA_W]
//   req_ready  out : one-hot grant, combinational in the handshake cycle
//   rel        in  : early release of the current hold window
//   clr_req    in  : synchronous clear request (priority over loads)
//   clr_ack    out : one-cycle clear acknowledge
//   q_data     out : shared register contents
//   q_owner    out : index of last granted requester
//   q_valid    out : high during the hold window
//   busy       out : arbiter not idle
//   grant_cnt  out : (stats build only) per-requester grant counts
module fdce_share_arb
  import fdce_share_arb_pkg::*;
#(
  parameter int                NUM_REQ     = 4,
  parameter int                DATA_W      = 8,
  parameter int                HOLD_CYCLES = 4,
  parameter logic [DATA_W-1:0] INIT        = {DATA_W{1'b0}},
  localparam int               OWN_W       = own_w(NUM_REQ)
) (
  input  logic                        C,
  input  logic                        _w_CLR,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        rel,
  input  logic                        clr_req,
  output logic                        clr_ack,
  output logic [DATA_W-1:0]           q_data,
  output logic [OWN_W-1:0]            q_owner,
  output logic                        q_valid,
  output logic                        busy
`ifdef FDCE_SHARE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*SAT_W-1:0]    grant_cnt
`endif
);

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [OWN_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] pick_grant;
  logic [OWN_W-1:0]   pick_idx;
  logic               pick_any;

  logic               idle;
  logic               do_clear;
  logic               do_load;
  logic [DATA_W-1:0]  load_d;
  logic               reg_ce;
  logic [DATA_W-1:0]  reg_d;

  fdce_share_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Handshakes are only offered in IDLE; reset masks them so the outputs
  // read zero as soon as _w_CLR rises, without waiting for a clock.
  assign idle      = (state == IDLE) && !_w_CLR;
  assign do_clear  = idle && clr_req;
  assign do_load   = idle && !clr_req && pick_any;
  assign req_ready = do_load ? pick_grant : '0;
  assign clr_ack   = do_clear;
  assign busy      = (state != IDLE);

  // One-hot mux of the winner's data slice.
  always_comb begin
    load_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        load_d = load_d | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // CE/D of the shared register: a clear loads zero, a grant loads data.
  assign reg_ce = do_load | do_clear;
  assign reg_d  = do_clear ? '0 : load_d;

  // FDCE-style capture register: async preset to INIT, clock-enabled load.
  always_ff @(posedge C or posedge _w_CLR) begin
    if (_w_CLR) begin
      q_data <= INIT;
    end else if (reg_ce) begin
      q_data <= reg_d;
    end
  end

  // Sequencer: grant/clear from IDLE, count down the hold window, one dead
  // cycle after a clear. The pointer moves only on grants.
  always_ff @(posedge C or posedge _w_CLR) begin
    if (_w_CLR) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rr_ptr   <= '0;
      q_owner  <= '0;
      q_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (do_clear) begin
            q_valid <= 1'b0;
            state   <= CLEAR;
          end else if (do_load) begin
            q_owner  <= pick_idx;
            q_valid  <= 1'b1;
            hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
            if (int'(pick_idx) == NUM_REQ - 1) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= pick_idx + 1'b1;
            end
            state <= HOLD;
          end
        end
        HOLD: begin
          if (rel || (hold_cnt == '0)) begin
            q_valid <= 1'b0;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FDCE_SHARE_ARB_STATS_EN
  logic [NUM_REQ-1:0][SAT_W-1:0] cnt_q;

  // Saturating grant counters; only reset clears them, clr_req does not.
  always_ff @(posedge C or posedge _w_CLR) begin
    if (_w_CLR) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (do_load && pick_grant[i] && (cnt_q[i] != {SAT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign grant_cnt = cnt_q;
`else
  // Statistics build disabled: no grant counters exist.
`endif

endmodule

// File: tb/tb_fdce_share_arb.sv
// tb_fdce_share_arb
// Scoreboard bench for fdce_share_arb (NUM_REQ=4, DATA_W=8, HOLD_CYCLES=4,
// INIT=8'h3C). The stimulus process computes expected outputs from a
// cycle-level model of the arbitration rules and queues them; a monitor pops
// and compares at each falling edge. Define FDCE_SHARE_ARB_STATS_EN to also
// check grant_cnt.
module tb_fdce_share_arb;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int HOLD_CYCLES = 4;
  localparam logic [7:0] INIT_VAL = 8'h3C;

  logic        C = 1'b0;
  logic        _w_CLR;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rel;
  logic        clr_req;
  logic        clr_ack;
  logic [7:0]  q_data;
  logic [1:0]  q_owner;
  logic        q_valid;
  logic        busy;
`ifdef FDCE_SHARE_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  fdce_share_arb #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .HOLD_CYCLES (HOLD_CYCLES),
    .INIT        (INIT_VAL)
  ) dut (
    .C         (C),
    ._w_CLR    (_w_CLR),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rel       (rel),
    .clr_req   (clr_req),
    .clr_ack   (clr_ack),
    .q_data    (q_data),
    .q_owner   (q_owner),
    .q_valid   (q_valid),
    .busy      (busy)
`ifdef FDCE_SHARE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 C = ~C;

  typedef struct {
    logic [3:0]  ready;
    logic        ack;
    logic        busy;
    logic [7:0]  data;
    logic [1:0]  owner;
    logic        valid;
    logic [63:0] gcnt;
  } exp_t;

  exp_t expQ[$];
  int total = 0;
  int bad   = 0;

  // Model: remaining cycles before the arbiter accepts again, remaining
  // cycles of q_valid, pointer, register image and grant tallies.
  int         mBlocked;
  int         mValidLeft;
  int         mPtr;
  int         mOwner;
  logic [7:0] mData;
  int         mGrants[4];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pickWinner(input logic [3:0] v, input int ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [63:0] packGrants();
    logic [63:0] g;
    g = '0;
    for (int i = 0; i < NUM_REQ; i++) g[i*16 +: 16] = 16'(mGrants[i]);
    return g;
  endfunction

  task automatic modelReset();
    mBlocked = 0; mValidLeft = 0; mPtr = 0; mOwner = 0; mData = INIT_VAL;
    for (int i = 0; i < NUM_REQ; i++) mGrants[i] = 0;
  endtask

  // Drive one cycle of inputs, queue the expected outputs for that cycle,
  // then advance the model across the coming rising edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d,
                               input logic r, input logic c);
    exp_t e;
    int   w;
    @(posedge C);
    #1;
    req_valid = v; req_data = d; rel = r; clr_req = c;
    e.ready = '0; e.ack = 1'b0;
    e.busy  = (mBlocked > 0);
    e.data  = mData;
    e.owner = 2'(mOwner);
    e.valid = (mValidLeft > 0);
    e.gcnt  = packGrants();
    if (mBlocked == 0) begin
      if (c) begin
        e.ack = 1'b1; mData = 8'h00; mValidLeft = 0; mBlocked = 1;
      end else begin
        w = pickWinner(v, mPtr);
        if (w >= 0) begin
          e.ready[w] = 1'b1;
          mData = d[w*8 +: 8];
          mOwner = w;
          mValidLeft = HOLD_CYCLES;
          mBlocked = HOLD_CYCLES;
          mPtr = (w + 1) % NUM_REQ;
          if (mGrants[w] < 65535) mGrants[w]++;
        end
      end
    end else if (mValidLeft > 0) begin
      if (r) begin
        mValidLeft = 0; mBlocked = 0;
      end else begin
        mValidLeft--; mBlocked--;
      end
    end else begin
      mBlocked--;
    end
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and check outputs without any clock edge.
  task automatic doReset();
    @(posedge C);
    #1;
    req_valid = 4'b1111; clr_req = 1'b1; rel = 1'b0;
    _w_CLR = 1'b1;
    #1;
    checkOutput("rst_q_data", 64'(q_data), 64'(INIT_VAL));
    checkOutput("rst_q_valid", 64'(q_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_q_owner", 64'(q_owner), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_clr_ack", 64'(clr_ack), 64'd0);
    @(posedge C);
    #1;
    _w_CLR = 1'b0; req_valid = 4'b0000; clr_req = 1'b0;
    modelReset();
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge C);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("req_ready", 64'(req_ready), 64'(e.ready));
        checkOutput("clr_ack", 64'(clr_ack), 64'(e.ack));
        checkOutput("busy", 64'(busy), 64'(e.busy));
        checkOutput("q_data", 64'(q_data), 64'(e.data));
        checkOutput("q_owner", 64'(q_owner), 64'(e.owner));
        checkOutput("q_valid", 64'(q_valid), 64'(e.valid));
`ifdef FDCE_SHARE_ARB_STATS_EN
        checkOutput("grant_cnt", grant_cnt, e.gcnt);
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    _w_CLR = 1'b1; req_valid = '0; req_data = '0; rel = 1'b0; clr_req = 1'b0;
    modelReset();
    repeat (2) @(posedge C);
    #1;
    _w_CLR = 1'b0;

    // Reset asserted in the middle of a hold window.
    applyStimulus(4'b0010, 32'h0000_7700, 1'b0, 1'b0);
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
    doReset();

    // Single requester 2 with data A5.
    applyStimulus(4'b0100, 32'h00A5_0000, 1'b0, 1'b0);
    idleCycles(6);

    // Fairness: all requesters continuously asserting.
    for (int i = 0; i < 22; i++) applyStimulus(4'b1111, 32'h4433_2211, 1'b0, 1'b0);
    idleCycles(6);

    // Clear beats a simultaneous request; grant follows after CLEAR.
    applyStimulus(4'b0001, 32'h0000_005A, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 32'h0000_005A, 1'b0, 1'b0);
    idleCycles(6);

    // Early release in the second hold cycle, then the next grant.
    applyStimulus(4'b1000, 32'hC300_0000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 32'hC300_0000, 1'b0, 1'b0);
    applyStimulus(4'b1001, 32'hC300_0011, 1'b1, 1'b0);
    applyStimulus(4'b0001, 32'h0000_0011, 1'b0, 1'b0);
    idleCycles(6);

    // Three grants to requester 1, then a clear.
    for (int g = 0; g < 3; g++) begin
      applyStimulus(4'b0010, 32'(g + 1) << 8, 1'b0, 1'b0);
      idleCycles(5);
    end
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1);
    idleCycles(3);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end
    idleCycles(2);

    @(negedge C);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
